// File: rtl/truth_table_sequencer.sv
// Clocked stimulus/response sweep for a 3-input combinational block: drives ABC 000..111,
// samples D after each hold, packs and checks the truth table. Optional macro: TT_FIRST_FAIL_EN.
module truth_table_sequencer #(
  parameter int HOLD_CYCLES = 20,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] exp_table,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] table_out
`ifdef TT_FIRST_FAIL_EN
  ,
  output logic [2:0] first_fail_idx,
  output logic       first_fail_vld
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       table_q, table_d;
  logic [7:0]       exp_q, exp_d;
  logic [2:0]       abc_q, abc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
`ifdef TT_FIRST_FAIL_EN
  logic [2:0]       ff_idx_q, ff_idx_d;
  logic             ff_vld_q, ff_vld_d;
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    exp_d   = exp_q;
    abc_d   = abc_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
`ifdef TT_FIRST_FAIL_EN
    ff_idx_d = ff_idx_q;
    ff_vld_d = ff_vld_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = 3'd0;
          cnt_d   = '0;
          table_d = 8'h00;
          exp_d   = exp_table;
          abc_d   = 3'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
`ifdef TT_FIRST_FAIL_EN
          ff_idx_d = 3'd0;
          ff_vld_d = 1'b0;
`endif
        end
      end
      RUN: begin
        if (cnt_q == HOLD_LAST) begin
          // End of hold: capture D for the current vector, then advance or finish.
          table_d[vec_q] = d;
          cnt_d          = '0;
`ifdef TT_FIRST_FAIL_EN
          if (!ff_vld_q && (d != exp_q[vec_q])) begin
            ff_idx_d = vec_q;
            ff_vld_d = 1'b1;
          end
`endif
          if (vec_q == 3'd7) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (table_d == exp_q);
            abc_d   = 3'd0;
          end else begin
            vec_d = vec_q + 3'd1;
            abc_d = vec_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= '0;
      table_q <= 8'h00;
      exp_q   <= 8'h00;
      abc_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef TT_FIRST_FAIL_EN
      ff_idx_q <= 3'd0;
      ff_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      exp_q   <= exp_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef TT_FIRST_FAIL_EN
      ff_idx_q <= ff_idx_d;
      ff_vld_q <= ff_vld_d;
`endif
    end
  end

  assign a         = abc_q[2];
  assign b         = abc_q[1];
  assign c         = abc_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign table_out = table_q;
`ifdef TT_FIRST_FAIL_EN
  assign first_fail_idx = ff_idx_q;
  assign first_fail_vld = ff_vld_q;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: a table-driven circuit model answers the sweep, and the
// expected per-cycle outputs are derived from cycle count, hold length and the circuit table.
module tb_truth_table_sequencer;

  localparam int H = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] exp_table;
  logic       a, b, c, d;
  logic       busy, done, pass;
  logic [7:0] table_out;
  logic [7:0] circ_tt;

  logic       f_start;
  logic       f_a, f_b, f_c, f_d;
  logic       f_busy, f_done, f_pass;
  logic [7:0] f_table_out;

`ifdef TT_FIRST_FAIL_EN
  logic [2:0] first_fail_idx, f_first_fail_idx;
  logic       first_fail_vld, f_first_fail_vld;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Circuit under stimulus: a lookup table indexed by the driven vector.
  assign d   = circ_tt[{a, b, c}];
  assign f_d = f_a ^ f_b ^ f_c;

  truth_table_sequencer #(.HOLD_CYCLES(H), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .exp_table(exp_table),
    .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done), .pass(pass), .table_out(table_out)
`ifdef TT_FIRST_FAIL_EN
    , .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld)
`endif
  );

  truth_table_sequencer #(.HOLD_CYCLES(1), .CNT_W(4)) u_fast (
    .clk(clk), .rst(rst), .start(f_start), .exp_table(8'h96),
    .a(f_a), .b(f_b), .c(f_c), .d(f_d),
    .busy(f_busy), .done(f_done), .pass(f_pass), .table_out(f_table_out)
`ifdef TT_FIRST_FAIL_EN
    , .first_fail_idx(f_first_fail_idx), .first_fail_vld(f_first_fail_vld)
`endif
  );

  // Expected {a,b,c,busy,done,pass,table_out} k cycles after the accepted start edge.
  function automatic logic [13:0] model_status(input int k, input int hold,
                                               input logic [7:0] circ, input logic [7:0] expv);
    int n;
    logic [7:0] mask;
    logic [2:0] vec;
    n    = (k / hold > 8) ? 8 : k / hold;
    mask = 8'h00;
    for (int i = 0; i < n; i++) mask[i] = 1'b1;
    vec  = (k < 8 * hold) ? 3'(k / hold) : 3'd0;
    return {vec, (k < 8 * hold), (k == 8 * hold), (k == 8 * hold) && (circ == expv), circ & mask};
  endfunction

  task automatic test_reset();
    checks++;
    if ({a, b, c, busy, done, pass, table_out} !== 14'd0) begin
      errors++;
      $display("FAIL reset_main got %b exp %b", {a, b, c, busy, done, pass, table_out}, 14'd0);
    end
    checks++;
    if ({f_a, f_b, f_c, f_busy, f_done, f_pass, f_table_out} !== 14'd0) begin
      errors++;
      $display("FAIL reset_fast got %b exp %b", {f_a, f_b, f_c, f_busy, f_done, f_pass, f_table_out}, 14'd0);
    end
`ifdef TT_FIRST_FAIL_EN
    checks++;
    if ({first_fail_idx, first_fail_vld} !== 4'd0) begin
      errors++;
      $display("FAIL reset_ff got %b exp 0000", {first_fail_idx, first_fail_vld});
    end
`endif
  endtask

  // One sweep on the H=20 instance. inject_k>=0 pulses start and scrambles exp_table mid-sweep;
  // abort_k>=0 asserts reset asynchronously mid-hold and ends the sweep there.
  task automatic run_sweep(input logic [7:0] circ, input logic [7:0] expv,
                           input int inject_k, input int abort_k, input string name);
    logic [13:0] exp_s;
    int          ff_idx;
    circ_tt   = circ;
    exp_table = expv;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 8 * H; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      start = 1'b0;
      exp_s = model_status(k, H, circ, expv);
      checks++;
      if ({a, b, c, busy, done, pass, table_out} !== exp_s) begin
        errors++;
        $display("FAIL %s status k=%0d got %b exp %b", name, k,
                 {a, b, c, busy, done, pass, table_out}, exp_s);
      end
      if (k == abort_k) begin
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({a, b, c, busy, done, pass, table_out} !== 14'd0) begin
          errors++;
          $display("FAIL %s async_reset got %b exp %b", name,
                   {a, b, c, busy, done, pass, table_out}, 14'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (k == inject_k) begin
        start     = 1'b1;
        exp_table = ~expv;
      end
    end
    exp_table = $urandom_range(0, 255);
`ifdef TT_FIRST_FAIL_EN
    ff_idx = -1;
    for (int i = 7; i >= 0; i--) if (circ[i] != expv[i]) ff_idx = i;
    checks++;
    if ({first_fail_vld, first_fail_idx} !== {(ff_idx >= 0), (ff_idx >= 0) ? 3'(ff_idx) : 3'd0}) begin
      errors++;
      $display("FAIL %s first_fail got vld=%b idx=%0d exp idx=%0d", name,
               first_fail_vld, first_fail_idx, ff_idx);
    end
`else
    ff_idx = 0;
`endif
    // DONE must hold steady until the next start.
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, pass, table_out} !== {1'b0, 1'b1, circ == expv, circ}) begin
      errors++;
      $display("FAIL %s done_hold got %b exp %b ff=%0d", name, {busy, done, pass, table_out},
               {1'b0, 1'b1, circ == expv, circ}, ff_idx);
    end
  endtask

  function automatic logic [7:0] or_and_not_model();
    logic [7:0] t;
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v    = 3'(i);
      t[i] = (v[2] | v[1]) & ~v[0];
    end
    return t;
  endfunction

  task automatic test_planned();
    run_sweep(or_and_not_model(), 8'h54, -1, -1, "plan_pass");
    run_sweep(or_and_not_model(), 8'h55, -1, -1, "plan_fail");
  endtask

  task automatic test_hold_one();
    logic [13:0] exp_s;
    f_start = 1'b1;
    @(posedge clk); #1;
    f_start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      exp_s = model_status(k, 1, 8'h96, 8'h96);
      checks++;
      if ({f_a, f_b, f_c, f_busy, f_done, f_pass, f_table_out} !== exp_s) begin
        errors++;
        $display("FAIL hold_one k=%0d got %b exp %b", k,
                 {f_a, f_b, f_c, f_busy, f_done, f_pass, f_table_out}, exp_s);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    run_sweep(8'hA7, 8'hA7, -1, 4 * H + 7, "rst_mid");
    run_sweep(8'hA7, 8'hA7, -1, -1, "after_rst");
  endtask

  task automatic test_start_while_busy();
    run_sweep(8'h3C, 8'h3C, 3 * H + 4, -1, "busy_start");
  endtask

  task automatic test_back_to_back();
    logic [7:0] circ, expv;
    repeat (4) begin
      circ = 8'($urandom_range(0, 255));
      expv = ($urandom_range(0, 1) == 1) ? circ : 8'($urandom_range(0, 255));
      run_sweep(circ, expv, -1, -1, "random_restart");
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    f_start   = 1'b0;
    exp_table = 8'h00;
    circ_tt   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_planned();
    test_hold_one();
    test_reset_mid_sweep();
    test_start_while_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
